// File: rtl/handshake_demux_2b.sv
// Clocked 4-phase req/ack demultiplexer: routes one upstream request to one of two
// downstream channels, relays the acknowledge back, and counts completed transfers.
module handshake_demux_2b #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_in,
    output logic              ack_in,
    input  logic              sel,
    input  logic [DATA_W-1:0] data_in,
    output logic [1:0]        req_out,
    input  logic [1:0]        ack_out,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1,
    output logic              proto_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FWD    = 2'd1,
        ACK_UP = 2'd2,
        REL    = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_nx;
    logic              cur_r;
    logic              cur_nx;
    logic [DATA_W-1:0] data_r;
    logic [DATA_W-1:0] data_nx;
    logic [CNT_W-1:0]  cnt0_r;
    logic [CNT_W-1:0]  cnt0_nx;
    logic [CNT_W-1:0]  cnt1_r;
    logic [CNT_W-1:0]  cnt1_nx;
    logic              err_r;
    logic              err_nx;
    logic [1:0]        req_out_r;
    logic [1:0]        req_out_nx;
    logic              ack_in_r;
    logic              ack_in_nx;

    logic [SYNC_STAGES-1:0] req_sync_r;
    logic [1:0]             ack_sync_r [SYNC_STAGES];
    logic                   req_s;
    logic [1:0]             ack_s;

    function automatic logic [1:0] chan_onehot(input logic chan);
        if (chan) begin
            return 2'b10;
        end else begin
            return 2'b01;
        end
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        if (val == {CNT_W{1'b1}}) begin
            return val;
        end else begin
            return val + CNT_W'(1);
        end
    endfunction

    // Synchronizer chains for the asynchronous request and acknowledge lines.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                req_sync_r[i] <= 1'b0;
                ack_sync_r[i] <= 2'b00;
            end
        end else begin
            req_sync_r[0] <= req_in;
            ack_sync_r[0] <= ack_out;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                req_sync_r[i] <= req_sync_r[i-1];
                ack_sync_r[i] <= ack_sync_r[i-1];
            end
        end
    end

    assign req_s = req_sync_r[SYNC_STAGES-1];
    assign ack_s = ack_sync_r[SYNC_STAGES-1];

    // Next-state, protocol checks, counters and next registered outputs.
    always_comb begin
        state_nx   = state_r;
        cur_nx     = cur_r;
        data_nx    = data_r;
        cnt0_nx    = cnt0_r;
        cnt1_nx    = cnt1_r;
        err_nx     = err_r;
        req_out_nx = 2'b00;
        ack_in_nx  = 1'b0;

        case (state_r)
            IDLE: begin
                // A request is held off while any downstream channel still acknowledges.
                if (req_s && (ack_s == 2'b00)) begin
                    state_nx = FWD;
                    cur_nx   = sel;
                    data_nx  = data_in;
                end else begin
                    state_nx = IDLE;
                end
            end
            FWD: begin
                if (ack_s[cur_r]) begin
                    state_nx = ACK_UP;
                end else begin
                    state_nx = FWD;
                end
                if (!req_s || ack_s[!cur_r]) begin
                    err_nx = 1'b1;
                end else begin
                    err_nx = err_r;
                end
            end
            ACK_UP: begin
                if (!req_s) begin
                    state_nx = REL;
                end else begin
                    state_nx = ACK_UP;
                end
                if (!ack_s[cur_r] || ack_s[!cur_r]) begin
                    err_nx = 1'b1;
                end else begin
                    err_nx = err_r;
                end
            end
            REL: begin
                if (!ack_s[cur_r]) begin
                    state_nx = IDLE;
                    if (cur_r) begin
                        cnt1_nx = sat_inc(cnt1_r);
                    end else begin
                        cnt0_nx = sat_inc(cnt0_r);
                    end
                end else begin
                    state_nx = REL;
                end
                if (ack_s[!cur_r]) begin
                    err_nx = 1'b1;
                end else begin
                    err_nx = err_r;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // Outputs are a function of the state being entered so they change on the same edge.
        case (state_nx)
            IDLE: begin
                req_out_nx = 2'b00;
                ack_in_nx  = 1'b0;
            end
            FWD: begin
                req_out_nx = chan_onehot(cur_nx);
                ack_in_nx  = 1'b0;
            end
            ACK_UP: begin
                req_out_nx = chan_onehot(cur_nx);
                ack_in_nx  = 1'b1;
            end
            REL: begin
                req_out_nx = 2'b00;
                ack_in_nx  = 1'b1;
            end
            default: begin
                req_out_nx = 2'b00;
                ack_in_nx  = 1'b0;
            end
        endcase
    end

    // State, latched channel/data, counters, error flag and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cur_r     <= 1'b0;
            data_r    <= {DATA_W{1'b0}};
            cnt0_r    <= {CNT_W{1'b0}};
            cnt1_r    <= {CNT_W{1'b0}};
            err_r     <= 1'b0;
            req_out_r <= 2'b00;
            ack_in_r  <= 1'b0;
        end else begin
            state_r   <= state_nx;
            cur_r     <= cur_nx;
            data_r    <= data_nx;
            cnt0_r    <= cnt0_nx;
            cnt1_r    <= cnt1_nx;
            err_r     <= err_nx;
            req_out_r <= req_out_nx;
            ack_in_r  <= ack_in_nx;
        end
    end

    assign req_out   = req_out_r;
    assign ack_in    = ack_in_r;
    assign data_out  = data_r;
    assign cnt0      = cnt0_r;
    assign cnt1      = cnt1_r;
    assign proto_err = err_r;

endmodule
